mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 4:1 bit-mux datapath among four requesters.
//   Owns the 2-bit mux select; grants one requester at a time, holds the grant for at most MAX_HOLD cycles.
//   Presents the granted requester's data with a valid flag.
//   Sits between request sources and the downstream consumer of the muxed output.
// PARAMETERS
//   DATA_W    1   width of each requester's data lane
//   MAX_HOLD  8   max consecutive cycles one requester may hold the grant (>=1)
// PORTS
//   clk         in   1         single clock, rising edge
//   rst_n       in   1         asynchronous, active-low reset
//   req         in   4         request per source; level-sensitive
//   din         in   4*DATA_W  data lanes; lane k = din[k*DATA_W +: DATA_W]
//   grant       out  4         one-hot grant, registered; 4'b0000 when idle
//   sel         out  2         registered mux select = index of granted source
//   dout        out  DATA_W    lane[sel] while granted, else all zeros
//   dout_valid  out  1         = |grant
//   busy        out  1         1 in state GRANT
// BEHAVIOUR
//   Reset (async, rst_n=0): grant=0, sel=0, dout=0, dout_valid=0, busy=0.
//     Internal: state=IDLE, ptr=0, hold_cnt=0. Outputs clear immediately, not at the next edge.
//   State machine has two states, IDLE and GRANT.
//   Priority search: winner = first k with req[k]=1, scanning ptr, ptr+1, ... mod 4.
//   IDLE:
//     - any req at an edge -> grant[winner]=1, sel=winner, hold_cnt=0, go GRANT.
//     - Latency: req to grant is 1 clock.
//   GRANT, release condition at an edge: req[sel]=0 OR hold_cnt==MAX_HOLD-1.
//     - Not releasing: hold grant, hold_cnt++.
//     - Releasing: ptr=(sel+1) mod 4; then re-search with the new ptr over the current req.
//       Winner found: grant moves to it on the same edge, hold_cnt=0. Back-to-back, no idle gap.
//       No winner: grant=0, go IDLE.
//     - At timeout, the current holder is still in req but now has lowest priority.
//       It regains the grant only if no other source is requesting.
//   Simultaneous requests: resolved purely by ptr order. Never more than one grant bit is set.
//   A source dropping req mid-tenure loses the grant at the next edge.
//     dout_valid stays 1 for that one cycle; the consumer qualifies data with req if it needs to.
//   MAX_HOLD=1: every grant lasts exactly one cycle; full rotation under continuous req.
//   hold_cnt width = $clog2(MAX_HOLD) (min 1). It never exceeds MAX_HOLD-1, so there is no wrap-around.
//   ptr wraps 3 -> 0.
//   dout: combinational from registered sel and din, gated by dout_valid. No added latency vs din.
//   req/din are synchronous to clk; no internal synchronisers.
// STRUCTURE
//   Shared package / header:
//     - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
//     - N_REQ=4, SEL_W=2
//   Sub-module mux4_lane (DATA_W-wide 4:1 mux, sel -> dout) for the datapath.
//   Arbiter FSM, ptr and hold_cnt live in this module.
// TESTING
//   1. rst_n=0 with req=4'hF, toggle clk
//      -> grant=0, sel=0, dout_valid=0, busy=0 throughout.
//   2. req=4'b0100 for 3 cycles, then 0; din lane2=1
//      -> grant=4'b0100, sel=2, dout=1 one clock after req.
//      -> grant=0 one edge after req drops; next ptr=3.
//   3. req=4'hF constant, MAX_HOLD=8
//      -> grants 0,1,2,3,0,... each exactly 8 cycles, no idle cycle between.
//   4. After a grant to source 3 releases, assert req=4'b1001 in the same cycle
//      -> source 0 wins (ptr=0); when source 0 releases, source 3 follows.
//   5. Pulse rst_n low mid-grant to source 2
//      -> grant clears asynchronously.
//      -> with req=4'b0110 after reset, source 1 is granted first (ptr=0).
//   6. MAX_HOLD=1, req=4'b1010 constant
//      -> grant alternates 4'b0010 / 4'b1000 every cycle.
//   Bench checks every cycle: $onehot0(grant), and sel == index(grant) whenever grant != 0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Round-robin search: first requester at or after ptr, wrapping mod N_REQ.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] k;
    p = '0;
    // Scan farthest-first so the nearest requester overwrites and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4_lane.sv
// DATA_W-wide 4:1 mux selecting one requester lane.
module mux_rr_arbiter_mux4_lane
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic [N_REQ*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       dout
);

  // Pure combinational lane select.
  always_comb begin
    dout = '0;
    unique case (sel)
      2'd0: dout = din[0*DATA_W +: DATA_W];
      2'd1: dout = din[1*DATA_W +: DATA_W];
      2'd2: dout = din[2*DATA_W +: DATA_W];
      2'd3: dout = din[3*DATA_W +: DATA_W];
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux datapath.
// Grants one requester at a time for at most MAX_HOLD consecutive cycles.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_valid,
  output logic                    busy
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] lane_out;

  pick_t pick_idle;
  pick_t pick_rel;
  logic  release_now;

  // State register; outputs clear the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state: arbitrate from idle, or hold / hand over on release.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    pick_idle   = rr_pick(req, ptr_q);
    // On release the holder moves to lowest priority before re-searching.
    pick_rel    = rr_pick(req, sel_q + SEL_W'(1));
    release_now = !req[sel_q] || (hold_q == HOLD_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_idle.found) begin
          grant_d = N_REQ'(1) << pick_idle.idx;
          sel_d   = pick_idle.idx;
          hold_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!release_now) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          ptr_d  = sel_q + SEL_W'(1);
          hold_d = '0;
          if (pick_rel.found) begin
            grant_d = N_REQ'(1) << pick_rel.idx;
            sel_d   = pick_rel.idx;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mux_rr_arbiter_mux4_lane #(
    .DATA_W(DATA_W)
  ) u_mux (
    .din (din),
    .sel (sel_q),
    .dout(lane_out)
  );

  // Outputs: registered grant/select, data gated by valid.
  always_comb begin
    grant      = grant_q;
    sel        = sel_q;
    dout_valid = |grant_q;
    busy       = (state_q == ST_GRANT);
    dout       = dout_valid ? lane_out : '0;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=1) on shared inputs,
// a per-instance reference model feeding a scoreboard, plus directed checks.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;

  logic [3:0] grant8, grant1;
  logic [1:0] sel8, sel1;
  logic       dout8, dout1;
  logic       valid8, valid1;
  logic       busy8, busy1;

  int n_run;
  int n_fail;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       dout;
    logic       valid;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state, index 0 = MAX_HOLD 8, index 1 = MAX_HOLD 1.
  int         m_busy [2];
  int         m_ptr  [2];
  int         m_hold [2];
  int         m_sel  [2];
  int         m_maxh [2];
  int         cyc;

  mux_rr_arbiter #(
    .DATA_W  (1),
    .MAX_HOLD(8)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .grant     (grant8),
    .sel       (sel8),
    .dout      (dout8),
    .dout_valid(valid8),
    .busy      (busy8)
  );

  mux_rr_arbiter #(
    .DATA_W  (1),
    .MAX_HOLD(1)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .grant     (grant1),
    .sel       (sel1),
    .dout      (dout1),
    .dout_valid(valid1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_ptr[i]  = 0;
      m_hold[i] = 0;
      m_sel[i]  = 0;
    end
  endtask

  // First requester scanning p, p+1, ... mod 4; -1 if none.
  function automatic int search(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Advance model i across one clock edge with the current req.
  task automatic model_step(input int i);
    int w;
    if (m_busy[i] == 0) begin
      w = search(req, m_ptr[i]);
      if (w >= 0) begin
        m_busy[i] = 1;
        m_sel[i]  = w;
        m_hold[i] = 0;
      end
    end else if (req[m_sel[i]] && (m_hold[i] < m_maxh[i] - 1)) begin
      m_hold[i] = m_hold[i] + 1;
    end else begin
      m_ptr[i] = (m_sel[i] + 1) % 4;
      w = search(req, m_ptr[i]);
      m_hold[i] = 0;
      if (w >= 0) m_sel[i] = w;
      else m_busy[i] = 0;
    end
  endtask

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.busy  = (m_busy[i] != 0);
    e.valid = e.busy;
    e.grant = e.busy ? (4'b0001 << m_sel[i]) : 4'b0000;
    e.sel   = 2'(m_sel[i]);
    e.dout  = e.busy ? din[m_sel[i]] : 1'b0;
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e, input logic [3:0] g, input logic [1:0] s,
                         input logic d, input logic v, input logic b);
    check_eq($sformatf("%s grant c%0d", name, cyc), {28'b0, g}, {28'b0, e.grant});
    check_eq($sformatf("%s dout/valid/busy c%0d", name, cyc), {29'b0, d, v, b},
             {29'b0, e.dout, e.valid, e.busy});
    if (e.grant != 4'b0000)
      check_eq($sformatf("%s sel c%0d", name, cyc), {30'b0, s}, {30'b0, e.sel});
    check_eq($sformatf("%s onehot0 c%0d", name, cyc), {31'b0, $onehot0(g)}, 32'd1);
    if (g != 4'b0000)
      check_eq($sformatf("%s sel==idx c%0d", name, cyc), {30'b0, s}, onehot_idx(g));
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    exp_t e0, e1;
    model_step(0);
    model_step(1);
    sb_q.push_back(model_out(0));
    sb_q.push_back(model_out(1));
    @(posedge clk);
    #1;
    e0 = sb_q.pop_front();
    e1 = sb_q.pop_front();
    compare("mh8", e0, grant8, sel8, dout8, valid8, busy8);
    compare("mh1", e1, grant1, sel1, dout1, valid1, busy1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " mh8"}, {27'b0, grant8, valid8, busy8}, 32'd0);
    check_eq({tag, " mh8 dout"}, {31'b0, dout8}, 32'd0);
    check_eq({tag, " mh1"}, {27'b0, grant1, valid1, busy1}, 32'd0);
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    cyc       = 0;
    m_maxh[0] = 8;
    m_maxh[1] = 1;
    model_reset();

    // 1. Reset held with all requests active.
    rst_n = 1'b0;
    req   = 4'hF;
    din   = 4'hF;
    #1;
    check_idle_outputs("reset t0");
    check_eq("reset sel", {30'b0, sel8}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_idle_outputs("reset hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
    din   = 4'b0000;
    cycle();

    // 2. Single requester 2, lane 2 data high.
    req = 4'b0100;
    din = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("t2 grant", {28'b0, grant8}, 32'h4);
      check_eq("t2 dout", {31'b0, dout8}, 32'd1);
    end
    req = 4'b0000;
    cycle();
    check_eq("t2 release", {28'b0, grant8}, 32'h0);

    // ptr is now 3, so source 3 beats source 0.
    req = 4'b1001;
    din = 4'b1000;
    cycle();
    check_eq("t4 ptr3", {28'b0, grant8}, 32'h8);
    req = 4'b0000;
    cycle();
    // 4. After source 3 releases, ptr=0: source 0 first, then source 3.
    req = 4'b1001;
    cycle();
    check_eq("t4 src0 first", {28'b0, grant8}, 32'h1);
    cycle();
    req = 4'b1000;
    cycle();
    check_eq("t4 src3 next", {28'b0, grant8}, 32'h8);
    req = 4'b0000;
    cycle();

    // 3. Continuous requests: 8-cycle tenures rotating 0,1,2,3,0.
    req = 4'hF;
    din = 4'b0101;
    for (int c = 0; c < 40; c++) begin
      cycle();
      check_eq($sformatf("t3 rot c%0d", c), {28'b0, grant8}, 32'h1 << ((c / 8) % 4));
    end

    // 5. Hand over to source 2, then reset asynchronously mid-cycle.
    req = 4'b0100;
    cycle();
    cycle();
    check_eq("t5 pre grant", {28'b0, grant8}, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5 async");
    model_reset();
    @(posedge clk);
    #1;
    check_idle_outputs("t5 in reset");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0110;
    cycle();
    check_eq("t5 src1 first", {28'b0, grant8}, 32'h2);

    // 6. MAX_HOLD=1 with two requesters alternates every cycle.
    req = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      cycle();
      check_eq($sformatf("t6 alt c%0d", c), {28'b0, grant1}, (c % 2 == 0) ? 32'h8 : 32'h2);
    end

    // Random traffic with sticky requests so tenures often reach the hold limit.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      din = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
